// File: rtl/vend_pkg.sv
// Shared encodings for the vending transaction controller: FSM states, coin values and the
// dispenser coin codes, plus the greedy change rule used when paying out.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StVend,
        StChange,
        StGap,
        StFault
    } vend_state_e;

    typedef enum logic [1:0] {
        DispNone = 2'b00,
        Disp5    = 2'b01,
        Disp10   = 2'b10,
        Disp20   = 2'b11
    } disp_coin_e;

    localparam int unsigned Coin5Val  = 1;
    localparam int unsigned Coin10Val = 2;
    localparam int unsigned Coin20Val = 4;

    // Largest coin not exceeding the amount, so the remaining credit can never underflow.
    function automatic disp_coin_e greedy_coin(input int unsigned amount);
        if (amount >= Coin20Val) begin
            return Disp20;
        end else if (amount >= Coin10Val) begin
            return Disp10;
        end else begin
            return Disp5;
        end
    endfunction

    function automatic int unsigned coin_value(input disp_coin_e coin);
        case (coin)
            Disp20:  return Coin20Val;
            Disp10:  return Coin10Val;
            Disp5:   return Coin5Val;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin acceptor / dispenser / status bundle of the vending controller.
// The slave side is the controller itself; the master side drives coins and acks.
interface vend_sequencer_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic                c5;
    logic                c10;
    logic                c20;
    logic                cancel;
    logic                disp_ack;
    logic                accepting;
    logic                coin_reject;
    logic                done;
    logic                disp_req;
    logic [1:0]          disp_coin;
    logic [CREDIT_W-1:0] credit;
    logic                fault;

    modport slave (
        input  c5, c10, c20, cancel, disp_ack,
        output accepting, coin_reject, done, disp_req, disp_coin, credit, fault
    );

    modport master (
        output c5, c10, c20, cancel, disp_ack,
        input  accepting, coin_reject, done, disp_req, disp_coin, credit, fault
    );
endinterface

// File: rtl/vend_change_dispenser.sv
// Pays out the amount presented while active, one greedy coin per req/ack handshake,
// and flags a timeout when the dispenser leaves a request unacknowledged too long.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                active_i,
    input  logic [CREDIT_W-1:0] amount_i,
    input  logic                ack_i,
    output logic                req_o,
    output logic [1:0]          coin_o,
    output logic                dec_o,
    output logic [CREDIT_W-1:0] dec_val_o,
    output logic                timeout_o
);
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    disp_coin_e      coin;

    // The amount only changes on an accepted ack, so the coin stays stable while requesting.
    always_comb begin
        coin       = greedy_coin(32'(amount_i));
        req_o      = active_i;
        coin_o     = active_i ? coin : DispNone;
        dec_o      = active_i && ack_i;
        dec_val_o  = CREDIT_W'(coin_value(coin));
        timeout_o  = active_i && !ack_i && (wait_cnt_q == CntW'(ACK_TIMEOUT - 1));
        wait_cnt_d = '0;
        if (active_i && !ack_i) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin arbitration, credit register and top-level sequencing.
// Change and refunds are paid out through vend_change_dispenser.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE       = 4,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned MAX_CREDIT  = 15,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input logic             clk_i,
    input logic             rst_ni,
    vend_sequencer_if.slave bus
);
    localparam int unsigned SumW = CREDIT_W + 1;

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          coin_val_q, coin_val_d;
    logic                coin_vld_q, coin_vld_d;
    logic                coin_lost_q, coin_lost_d;
    logic                reject_q, reject_d;

    logic [SumW-1:0]     credit_sum;
    logic                collecting;
    logic                cancel_take;
    logic                coin_ok;
    logic                disp_req;
    logic                disp_dec;
    logic                disp_timeout;
    logic [1:0]          disp_coin;
    logic [CREDIT_W-1:0] disp_dec_val;

    // The winning coin is registered and credited one cycle after sampling.
    always_comb begin
        coin_vld_d  = bus.c20 | bus.c10 | bus.c5;
        coin_lost_d = (bus.c20 & (bus.c10 | bus.c5)) | (bus.c10 & bus.c5);
        if (bus.c20) begin
            coin_val_d = 3'(Coin20Val);
        end else if (bus.c10) begin
            coin_val_d = 3'(Coin10Val);
        end else if (bus.c5) begin
            coin_val_d = 3'(Coin5Val);
        end else begin
            coin_val_d = '0;
        end
    end

    always_comb begin
        credit_sum  = {1'b0, credit_q} + SumW'(coin_val_q);
        collecting  = (state_q == StIdle) || (state_q == StCollect);
        cancel_take = bus.cancel && (state_q == StCollect);
        coin_ok     = coin_vld_q && collecting && !cancel_take &&
                      (credit_sum <= SumW'(MAX_CREDIT));
        reject_d    = coin_lost_q || (coin_vld_q && !coin_ok);
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        if (coin_ok) begin
            credit_d = credit_sum[CREDIT_W-1:0];
        end
        unique case (state_q)
            StIdle: begin
                if (coin_ok) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (cancel_take) begin
                    state_d = StChange;
                end else if (credit_q >= CREDIT_W'(PRICE)) begin
                    state_d = StVend;
                end
            end
            StVend: begin
                credit_d = credit_q - CREDIT_W'(PRICE);
                state_d  = (credit_q == CREDIT_W'(PRICE)) ? StIdle : StChange;
            end
            StChange: begin
                if (disp_dec) begin
                    credit_d = credit_q - disp_dec_val;
                    state_d  = StGap;
                end else if (disp_timeout) begin
                    state_d = StFault;
                end
            end
            StGap: begin
                state_d = (credit_q != '0) ? StChange : StIdle;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            credit_q    <= '0;
            coin_val_q  <= '0;
            coin_vld_q  <= 1'b0;
            coin_lost_q <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            coin_val_q  <= coin_val_d;
            coin_vld_q  <= coin_vld_d;
            coin_lost_q <= coin_lost_d;
            reject_q    <= reject_d;
        end
    end

    vend_change_dispenser #(
        .CREDIT_W    (CREDIT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dispenser (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .active_i  (state_q == StChange),
        .amount_i  (credit_q),
        .ack_i     (bus.disp_ack),
        .req_o     (disp_req),
        .coin_o    (disp_coin),
        .dec_o     (disp_dec),
        .dec_val_o (disp_dec_val),
        .timeout_o (disp_timeout)
    );

    assign bus.accepting   = collecting;
    assign bus.coin_reject = reject_q;
    assign bus.done        = (state_q == StVend);
    assign bus.disp_req    = disp_req;
    assign bus.disp_coin   = disp_coin;
    assign bus.credit      = credit_q;
    assign bus.fault       = (state_q == StFault);

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus a randomized coin/cancel session checked
// against an arithmetic credit model; a second instance with PRICE=15 exercises the credit ceiling.
module tb_vend_sequencer;
    localparam int unsigned PRICE      = 4;
    localparam int unsigned MAX_CREDIT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_sequencer_if #(.CREDIT_W(4)) vif ();
    vend_sequencer_if #(.CREDIT_W(4)) vif15 ();

    vend_sequencer #(
        .PRICE(PRICE), .CREDIT_W(4), .MAX_CREDIT(MAX_CREDIT), .ACK_TIMEOUT(15)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (vif)
    );

    vend_sequencer #(
        .PRICE(15), .CREDIT_W(4), .MAX_CREDIT(15), .ACK_TIMEOUT(15)
    ) u_dut15 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (vif15)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Dispenser model and event monitor: acks in the 2nd cycle of each request unless held.
    int         n_done = 0, n_rej = 0;
    int         req_age = 0, high_run = 0, low_run = 0, last_gap = 0, last_high = 0;
    bit         ack_hold = 1'b0;
    logic [1:0] disp_log[$];

    always @(negedge clk) begin
        if (vif.done) n_done++;
        if (vif.coin_reject) n_rej++;
        if (!vif.disp_req) begin
            check("coin_zero_when_idle", vif.disp_coin, 0);
            if (high_run != 0) last_high = high_run;
            high_run     = 0;
            req_age      = 0;
            low_run++;
            vif.disp_ack = 1'b0;
        end else begin
            if (high_run == 0) last_gap = low_run;
            low_run = 0;
            high_run++;
            req_age++;
            if (!ack_hold && req_age == 2) begin
                vif.disp_ack = 1'b1;
                disp_log.push_back(vif.disp_coin);
            end else begin
                vif.disp_ack = 1'b0;
            end
        end
    end

    task automatic coin(input logic [2:0] m);
        vif.c20 = m[2]; vif.c10 = m[1]; vif.c5 = m[0];
        @(negedge clk);
        vif.c20 = 1'b0; vif.c10 = 1'b0; vif.c5 = 1'b0;
    endtask

    task automatic coin15(input logic [2:0] m);
        vif15.c20 = m[2]; vif15.c10 = m[1]; vif15.c5 = m[0];
        @(negedge clk);
        vif15.c20 = 1'b0; vif15.c10 = 1'b0; vif15.c5 = 1'b0;
    endtask

    task automatic pulse_cancel();
        vif.cancel = 1'b1;
        @(negedge clk);
        vif.cancel = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        repeat (3) @(negedge clk);
        while (!(vif.accepting && !vif.disp_req && vif.credit < PRICE) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_settle_in_time"}, (k < 200), 1);
    endtask

    // Greedy payout of an amount in 5c units, as coin codes.
    function automatic void greedy(input int amount, inout logic [1:0] q[$]);
        int a = amount;
        while (a > 0) begin
            if (a >= 4) begin q.push_back(2'b11); a -= 4; end
            else if (a >= 2) begin q.push_back(2'b10); a -= 2; end
            else begin q.push_back(2'b01); a -= 1; end
        end
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, l0, k, m, exp_done, exp_rej, v;
        logic [2:0] mask;
        logic [1:0] exp_log[$];

        vif.c5 = 0; vif.c10 = 0; vif.c20 = 0; vif.cancel = 0;
        vif15.c5 = 0; vif15.c10 = 0; vif15.c20 = 0; vif15.cancel = 0; vif15.disp_ack = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_accepting", vif.accepting, 1);
        check("rst_credit", vif.credit, 0);
        check("rst_done", vif.done, 0);
        check("rst_req", vif.disp_req, 0);
        check("rst_coin", vif.disp_coin, 0);
        check("rst_fault", vif.fault, 0);
        check("rst_reject", vif.coin_reject, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // c20 from reset: exact vend without change
        d0 = n_done; l0 = disp_log.size();
        coin(3'b100);
        check("c20_pending", vif.credit, 0);
        @(negedge clk);
        check("c20_credit", vif.credit, 4);
        @(negedge clk);
        check("c20_done", vif.done, 1);
        check("c20_flap_closed", vif.accepting, 0);
        @(negedge clk);
        check("c20_done_once", vif.done, 0);
        check("c20_credit_end", vif.credit, 0);
        check("c20_idle", vif.accepting, 1);
        check("c20_no_req", disp_log.size() - l0, 0);
        check("c20_done_count", n_done - d0, 1);

        // c10,c5,c20 -> 7, vend, change 10c then 5c with one gap cycle
        d0 = n_done; l0 = disp_log.size();
        coin(3'b010); @(negedge clk); check("seq_credit2", vif.credit, 2);
        coin(3'b001); @(negedge clk); check("seq_credit3", vif.credit, 3);
        coin(3'b100); @(negedge clk); check("seq_credit7", vif.credit, 7);
        wait_quiet("seq");
        check("seq_done", n_done - d0, 1);
        check("seq_ncoins", disp_log.size() - l0, 2);
        check("seq_coin0", disp_log[l0], 2'b10);
        check("seq_coin1", disp_log[l0+1], 2'b01);
        check("seq_gap", last_gap, 1);
        check("seq_credit_end", vif.credit, 0);

        // Cancel refund with a coin inserted during the payout
        d0 = n_done; l0 = disp_log.size();
        coin(3'b010); @(negedge clk);
        coin(3'b001); @(negedge clk);
        check("cancel_credit3", vif.credit, 3);
        r0 = n_rej;
        pulse_cancel();
        check("cancel_flap_closed", vif.accepting, 0);
        coin(3'b001);
        wait_quiet("cancel");
        check("cancel_no_done", n_done - d0, 0);
        check("cancel_reject", n_rej - r0, 1);
        check("cancel_ncoins", disp_log.size() - l0, 2);
        check("cancel_coin0", disp_log[l0], 2'b10);
        check("cancel_coin1", disp_log[l0+1], 2'b01);
        check("cancel_credit_end", vif.credit, 0);

        // Simultaneous c20 & c5: only c20 credited
        d0 = n_done; r0 = n_rej;
        coin(3'b101); @(negedge clk);
        check("simul_credit", vif.credit, 4);
        check("simul_reject", vif.coin_reject, 1);
        wait_quiet("simul");
        check("simul_reject_once", n_rej - r0, 1);
        check("simul_done", n_done - d0, 1);

        // Credit ceiling on the PRICE=15 instance
        coin15(3'b100); @(negedge clk); check("max_c4", vif15.credit, 4);
        coin15(3'b100); @(negedge clk); check("max_c8", vif15.credit, 8);
        coin15(3'b100); @(negedge clk); check("max_c12", vif15.credit, 12);
        coin15(3'b010); @(negedge clk); check("max_c14", vif15.credit, 14);
        coin15(3'b100); @(negedge clk);
        check("max_over_credit", vif15.credit, 14);
        check("max_over_reject", vif15.coin_reject, 1);
        coin15(3'b001);
        coin15(3'b001);
        check("max_c15", vif15.credit, 15);
        @(negedge clk);
        check("max_at15_reject", vif15.coin_reject, 1);
        check("max_at15_done", vif15.done, 1);
        @(negedge clk);
        check("max_vend_credit", vif15.credit, 0);
        check("max_idle", vif15.accepting, 1);

        // Dispenser never acks -> FAULT after 15 request cycles
        ack_hold = 1'b1;
        coin(3'b010); @(negedge clk);
        coin(3'b001); @(negedge clk);
        coin(3'b100);
        k = 0;
        while (!vif.fault && k < 100) begin @(negedge clk); k++; end
        check("fault_reached", (k < 100), 1);
        @(negedge clk);
        check("fault_req_cycles", last_high, 15);
        check("fault_flag", vif.fault, 1);
        check("fault_req_low", vif.disp_req, 0);
        check("fault_flap_closed", vif.accepting, 0);
        check("fault_credit_frozen", vif.credit, 3);
        coin(3'b001); @(negedge clk);
        check("fault_coin_reject", vif.coin_reject, 1);
        check("fault_sticky", vif.fault, 1);
        rst_n = 1'b0;
        #1;
        check("fault_rst_clear", vif.fault, 0);
        check("fault_rst_credit", vif.credit, 0);
        check("fault_rst_accepting", vif.accepting, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_hold = 1'b0;
        @(negedge clk);

        // Asynchronous reset while a change request is outstanding
        coin(3'b010); @(negedge clk);
        coin(3'b001); @(negedge clk);
        coin(3'b100);
        k = 0;
        while (!vif.disp_req && k < 50) begin @(negedge clk); k++; end
        check("midrst_req_seen", (k < 50), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", vif.disp_req, 0);
        check("midrst_coin", vif.disp_coin, 0);
        check("midrst_credit", vif.credit, 0);
        check("midrst_done", vif.done, 0);
        check("midrst_fault", vif.fault, 0);
        check("midrst_reject", vif.coin_reject, 0);
        check("midrst_accepting", vif.accepting, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_idle_req", vif.disp_req, 0);
        check("midrst_idle_credit", vif.credit, 0);
        check("midrst_idle_accepting", vif.accepting, 1);

        // Randomized session against the credit model
        m = 0; exp_done = 0; exp_rej = 0;
        d0 = n_done; r0 = n_rej; l0 = disp_log.size();
        exp_log.delete();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                pulse_cancel();
                if (m > 0) begin
                    greedy(m, exp_log);
                    m = 0;
                end
            end else begin
                mask = 3'($urandom_range(1, 7));
                coin(mask);
                v = mask[2] ? 4 : (mask[1] ? 2 : 1);
                if ($countones(mask) > 1 || m + v > MAX_CREDIT) exp_rej++;
                if (m + v <= MAX_CREDIT) m += v;
                if (m >= PRICE) begin
                    exp_done++;
                    greedy(m - PRICE, exp_log);
                    m = 0;
                end
            end
            wait_quiet("rand");
            check("rand_credit", vif.credit, m);
            check("rand_done", n_done - d0, exp_done);
            check("rand_reject", n_rej - r0, exp_rej);
        end
        check("rand_ncoins", disp_log.size() - l0, exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            check("rand_coin", disp_log[l0+i], exp_log[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
